ws2812_frame_driver: RTL and testbench
======================================

Name: ws2812_frame_driver

Overview:
- Downstream stage of the LED colour processor. Consumes the pixel RAM that the processor fills.
- On an update request, it reads LED_NUM 24-bit words from the RAM and serialises them onto a single-wire WS2812 data line (NRZ pulse-width coding). It then holds the line low for the latch/reset gap.
- It reports completion to the processor on update_done.

Parameters:
- LED_NUM, 16, number of pixels per frame.
- ADDR_BIT, $clog2(LED_NUM)+1, RAM address width; matches the processor's write address.
- T0H_CYC, 40, CLK cycles DOUT is high for a '0' bit (0.40 us at 100 MHz).
- T1H_CYC, 80, CLK cycles DOUT is high for a '1' bit (0.80 us).
- TBIT_CYC, 125, total bit period in cycles (1.25 us). Must exceed T1H_CYC.
- TRES_CYC, 30000, low latch gap after the last bit (300 us).

Ports:
- CLK  in  1  system clock (100 MHz nominal).
- RST_N  in  1  asynchronous active-low reset.
- update_request  in  1  frame start request from the processor; a level held at least 1 cycle.
- update_done  out  1  1 = idle/frame complete; 0 = frame in progress.
- busy  out  1  inverse of update_done, for status/debug.
- ram_rdaddress  out  ADDR_BIT  pixel RAM read address.
- ram_rden  out  1  read enable, one cycle per fetch.
- ram_q  in  24  RAM read data; valid exactly 1 CLK after address/rden.
- DOUT  out  1  WS2812 serial data line.

Behaviour:
- Reset is async, active-low, and applies at any time, including mid-frame. Reset values:
  - DOUT=0, update_done=1, busy=0, ram_rdaddress=0, ram_rden=0.
  - Internal counters cleared; FSM goes to IDLE.
- Start condition: rising edge of update_request, registered edge detect, sampled in IDLE. Let t be the cycle in which the edge is seen.
  - t+1: update_done=0, busy=1, ram_rdaddress=0, ram_rden=1.
  - t+2: word 0 loaded into the shift register.
  - t+3: first DOUT high.
- Request edges while busy are ignored, not queued. A request level still high on return to IDLE does not restart; a new rising edge is required.
- Wire format: 24 bits per pixel, MSB first. RAM word is {G[7:0],R[7:0],B[7:0]}.
  - Each bit starts with DOUT=1 for T0H_CYC ('0') or T1H_CYC ('1').
  - DOUT is then 0 for the remainder of TBIT_CYC.
- Bit periods are contiguous across pixel boundaries, with no gap cycles. The next word is prefetched:
  - address/rden issued on the first cycle of bit 23's period;
  - word captured into a holding register one cycle later;
  - word transferred to the shift register at the bit boundary.
- No fetch is issued after pixel LED_NUM-1. ram_rdaddress stays at LED_NUM-1 until IDLE, where it returns to 0.
- FSM states:
  - IDLE: wait for request edge.
  - FETCH0: first read issued.
  - LOAD0: capture word 0.
  - BIT_HIGH: DOUT=1, count to TxH_CYC.
  - BIT_LOW: DOUT=0, count to TBIT_CYC. Then go to BIT_HIGH for the next bit/pixel, or to LATCH after the last bit.
  - LATCH: DOUT=0 for TRES_CYC cycles, then return to IDLE.
- update_done returns to 1 on the cycle the FSM enters IDLE. Total busy time is 2 + LED_NUM*24*TBIT_CYC + TRES_CYC cycles.
- Counter widths:
  - phase counter: $clog2(max(TBIT_CYC,TRES_CYC)+1);
  - bit counter: 5 bits, range 0..23;
  - pixel counter: ADDR_BIT.
  - No wrap is permitted within a frame.
- LED_NUM=1 is legal: the prefetch is suppressed and only word 0 is sent.
- DOUT is registered (glitch-free). Pulse widths are exact to the cycle.

Optional Feature:
- Macro: WS2812_RGB_ORDER_EN.
- Defined: the RAM word is interpreted as {R,G,B} and reordered to {G,R,B} at shift-register load. Wire order is still G,R,B MSB-first.
- Undefined: the RAM word is sent as stored.

Decomposition:
- Shared package ws2812_pkg holds:
  - FSM state enum;
  - default timing constants (T0H/T1H/TBIT/TRES at 100 MHz);
  - the 24-bit pixel typedef with G/R/B field positions.
- One natural sub-module, ws2812_bit_encoder: takes a bit plus a strobe, produces one TBIT_CYC-long pulse on DOUT, and signals bit_done. The frame FSM, fetch logic and shift register stay in the top.

Test Plan:
- Reset check: assert RST_N=0 → DOUT=0, update_done=1, busy=0, ram_rdaddress=0.
- Frame encoding (LED_NUM=2, T0H=2, T1H=4, TBIT=6, TRES=20; RAM[0]=24'hF0F0F0, RAM[1]=24'h000001):
  - 48 bits decoded as high widths 4,4,4,4,2,2,2,2,... with the last bit 4;
  - periods exactly 6, with no gap between pixels;
  - first DOUT rise at t+3.
- Done timing, same config: update_done=0 at t+1, back to 1 exactly 2+288+20 cycles later. DOUT is low throughout the last 20.
- Request re-pulsed mid-frame: no restart, frame length unchanged. A new rising edge after done starts a second identical frame.
- Reset mid-frame (RST_N low at bit 30): DOUT=0 and update_done=1 immediately. The next request sends the full frame from address 0.
- With WS2812_RGB_ORDER_EN defined and RAM[0]=24'hFF0000 (red): the wire carries 8 zeros, then 8 ones, then 8 zeros.

Source files
------------

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared FSM state, default 100 MHz timing and pixel layout for the WS2812 driver.
package ws2812_pkg;
  typedef enum logic [2:0] {IDLE, FETCH0, LOAD0, BIT_HIGH, BIT_LOW, LATCH} state_t;
  localparam int LED_NUM_DEF = 16;
  localparam int T0H_DEF = 40;
  localparam int T1H_DEF = 80;
  localparam int TBIT_DEF = 125;
  localparam int TRES_DEF = 30000;
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } pixel_t;
endpackage

// File: rtl/ws2812_frame_driver_if.sv
// ws2812_frame_driver_if: update handshake and pixel RAM read port between processor and frame driver.
interface ws2812_frame_driver_if
  import ws2812_pkg::*;
#(
  parameter int ADDR_BIT = 5
);
  logic update_request;
  logic update_done;
  logic busy;
  logic [ADDR_BIT-1:0] ram_rdaddress;
  logic ram_rden;
  pixel_t ram_q;
  modport master (output update_request, ram_q, input update_done, busy, ram_rdaddress, ram_rden);
  modport slave (input update_request, ram_q, output update_done, busy, ram_rdaddress, ram_rden);
endinterface

// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder: turns a strobed bit into one NRZ bit period on a registered data line.
module ws2812_bit_encoder #(
  parameter int T0H_CYC = 40,
  parameter int T1H_CYC = 80,
  parameter int TBIT_CYC = 125
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_bit,
  input  logic i_strobe,
  output logic o_dout,
  output logic o_high_done,
  output logic o_bit_done
);
  localparam int CW = $clog2(TBIT_CYC + 1);
  logic r_act, r_dout;
  logic [CW-1:0] r_cnt, r_th;
  assign o_dout = r_dout;
  assign o_high_done = r_act && r_cnt == r_th;
  assign o_bit_done = r_act && r_cnt == CW'(TBIT_CYC);
  // A strobe on the bit_done cycle restarts the period, so consecutive bits abut.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_act <= 1'b0;
      r_dout <= 1'b0;
      r_cnt <= '0;
      r_th <= '0;
    end else if (i_strobe) begin
      r_act <= 1'b1;
      r_dout <= 1'b1;
      r_cnt <= CW'(1);
      r_th <= i_bit ? CW'(T1H_CYC) : CW'(T0H_CYC);
    end else if (r_act) begin
      r_cnt <= r_cnt + 1'b1;
      if (o_high_done) r_dout <= 1'b0;
      if (o_bit_done) r_act <= 1'b0;
    end
  end
endmodule

// File: rtl/ws2812_frame_driver.sv
// ws2812_frame_driver: fetches LED_NUM pixels from RAM and streams them as WS2812 bits, then latches.
// Define WS2812_RGB_ORDER_EN when the RAM holds {R,G,B}; words are reordered to wire order {G,R,B}.
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int LED_NUM = LED_NUM_DEF,
  parameter int ADDR_BIT = $clog2(LED_NUM) + 1,
  parameter int T0H_CYC = T0H_DEF,
  parameter int T1H_CYC = T1H_DEF,
  parameter int TBIT_CYC = TBIT_DEF,
  parameter int TRES_CYC = TRES_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  ws2812_frame_driver_if.slave bus,
  output logic DOUT
);
  localparam int PH_MAX = TBIT_CYC > TRES_CYC ? TBIT_CYC : TRES_CYC;
  localparam int PH_W = $clog2(PH_MAX + 1);
  localparam logic [ADDR_BIT-1:0] LAST_PIX = ADDR_BIT'(LED_NUM - 1);
  state_t r_state;
  logic r_req_d, r_done, r_busy, r_rden, r_cap;
  logic [ADDR_BIT-1:0] r_addr, r_pix;
  logic [4:0] r_bit;
  logic [PH_W-1:0] r_ph;
  logic [23:0] r_sr, r_hold, w_next;
  pixel_t w_q;
  logic w_edge, w_last, w_strobe, w_high_done, w_bit_done;
`ifdef WS2812_RGB_ORDER_EN
  assign w_q = '{g: bus.ram_q.r, r: bus.ram_q.g, b: bus.ram_q.b};
`else
  assign w_q = bus.ram_q;
`endif
  assign w_edge = bus.update_request & ~r_req_d;
  assign w_last = r_bit == 5'd23 && r_pix == LAST_PIX;
  assign w_next = r_state == LOAD0 ? w_q : r_bit == 5'd23 ? r_hold : {r_sr[22:0], 1'b0};
  assign w_strobe = r_state == LOAD0 || (r_state == BIT_LOW && w_bit_done && !w_last);
  assign bus.update_done = r_done;
  assign bus.busy = r_busy;
  assign bus.ram_rdaddress = r_addr;
  assign bus.ram_rden = r_rden;
  ws2812_bit_encoder #(.T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC), .TBIT_CYC(TBIT_CYC)) u_enc (
    .CLK(CLK), .RST_N(RST_N), .i_bit(w_next[23]), .i_strobe(w_strobe),
    .o_dout(DOUT), .o_high_done(w_high_done), .o_bit_done(w_bit_done)
  );
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_req_d <= 1'b0;
      r_done <= 1'b1;
      r_busy <= 1'b0;
      r_rden <= 1'b0;
      r_cap <= 1'b0;
      r_addr <= '0;
      r_pix <= '0;
      r_bit <= '0;
      r_ph <= '0;
      r_sr <= '0;
      r_hold <= '0;
    end else begin
      r_req_d <= bus.update_request;
      r_cap <= r_rden;
      r_rden <= 1'b0;
      if (r_cap) r_hold <= w_q;
      if (w_strobe) r_sr <= w_next;
      case (r_state)
        IDLE: if (w_edge) begin
          r_state <= FETCH0;
          r_done <= 1'b0;
          r_busy <= 1'b1;
          r_addr <= '0;
          r_rden <= 1'b1;
        end
        FETCH0: r_state <= LOAD0;
        LOAD0: begin
          r_state <= BIT_HIGH;
          r_bit <= '0;
          r_pix <= '0;
        end
        BIT_HIGH: if (w_high_done) r_state <= BIT_LOW;
        BIT_LOW: if (w_bit_done) begin
          if (w_last) begin
            r_state <= LATCH;
            r_ph <= PH_W'(1);
          end else begin
            r_state <= BIT_HIGH;
            r_bit <= r_bit == 5'd23 ? 5'd0 : r_bit + 5'd1;
            if (r_bit == 5'd23) r_pix <= r_pix + 1'b1;
            // Prefetch the next word as bit 23 of the current one begins.
            if (r_bit == 5'd22 && r_pix != LAST_PIX) begin
              r_addr <= r_pix + 1'b1;
              r_rden <= 1'b1;
            end
          end
        end
        LATCH: if (r_ph == PH_W'(TRES_CYC)) begin
          r_state <= IDLE;
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_addr <= '0;
        end else r_ph <= r_ph + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_frame_driver.sv
// tb_ws2812_frame_driver: directed checks of frame encoding, done timing, re-requests and mid-frame reset.
module tb_ws2812_frame_driver;
  import ws2812_pkg::*;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic DOUT;
  int n_tests = 0;
  int n_fail = 0;
  localparam int NS = 340;
`ifdef WS2812_RGB_ORDER_EN
  localparam logic [23:0] RAM0 = 24'hFF0000;
  localparam logic [23:0] WIRE0 = 24'h00FF00;
`else
  localparam logic [23:0] RAM0 = 24'hF0F0F0;
  localparam logic [23:0] WIRE0 = 24'hF0F0F0;
`endif
  localparam logic [47:0] EXP_BITS = {WIRE0, 24'h000001};
  logic [23:0] mem [0:3];
  logic s_dout [0:NS];
  logic s_done [0:NS];
  logic s_busy [0:NS];
  logic s_rden [0:NS];
  logic [1:0] s_addr [0:NS];
  always #5 CLK = ~CLK;
  ws2812_frame_driver_if #(.ADDR_BIT(2)) bus ();
  ws2812_frame_driver #(
    .LED_NUM(2), .ADDR_BIT(2), .T0H_CYC(2), .T1H_CYC(4), .TBIT_CYC(6), .TRES_CYC(20)
  ) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus), .DOUT(DOUT));
  always @(posedge CLK) if (bus.ram_rden) bus.ram_q <= mem[bus.ram_rdaddress];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run_frame(input int rep_at);
    @(negedge CLK);
    bus.update_request = 1'b1;
    for (int i = 1; i <= NS; i++) begin
      @(negedge CLK);
      s_dout[i] = DOUT;
      s_done[i] = bus.update_done;
      s_busy[i] = bus.busy;
      s_rden[i] = bus.ram_rden;
      s_addr[i] = bus.ram_rdaddress;
      if (rep_at != 0 && i == rep_at) bus.update_request = 1'b0;
      if (rep_at != 0 && i == rep_at + 2) bus.update_request = 1'b1;
    end
  endtask
  task automatic check_frame(input string tag);
    int nr, nh;
    chk({tag, "_done_t1"}, 32'(s_done[1]), 0);
    chk({tag, "_busy_t1"}, 32'(s_busy[1]), 1);
    chk({tag, "_rden_t1"}, 32'(s_rden[1]), 1);
    chk({tag, "_addr_t1"}, 32'(s_addr[1]), 0);
    chk({tag, "_dout_t2"}, 32'(s_dout[2]), 0);
    chk({tag, "_dout_t3"}, 32'(s_dout[3]), 1);
    for (int k = 0; k < 48; k++) begin
      int b, run, ones;
      b = 3 + 6 * k;
      run = 0;
      ones = 0;
      for (int j = 0; j < 6; j++) if (s_dout[b + j] === 1'b1) ones++;
      for (int j = 0; j < 6 && s_dout[b + j] === 1'b1; j++) run++;
      chk($sformatf("%s_bit%0d_width", tag, k), run == ones ? run : 99, EXP_BITS[47 - k] ? 4 : 2);
    end
    chk({tag, "_pref_rden"}, 32'(s_rden[141]), 1);
    chk({tag, "_pref_addr"}, 32'(s_addr[141]), 1);
    nr = 0;
    for (int i = 2; i <= NS; i++) if (s_rden[i] === 1'b1) nr++;
    chk({tag, "_fetch_count"}, nr, 1);
    chk({tag, "_addr_hold"}, 32'(s_addr[300]), 1);
    nh = 0;
    for (int i = 291; i <= 310; i++) if (s_dout[i] !== 1'b0) nh++;
    chk({tag, "_latch_high_cycles"}, nh, 0);
    chk({tag, "_done_t310"}, 32'(s_done[310]), 0);
    chk({tag, "_done_t311"}, 32'(s_done[311]), 1);
    chk({tag, "_busy_t311"}, 32'(s_busy[311]), 0);
    chk({tag, "_addr_idle"}, 32'(s_addr[311]), 0);
    chk({tag, "_no_restart"}, 32'(s_done[NS]), 1);
  endtask
  initial begin
    mem[0] = RAM0;
    mem[1] = 24'h000001;
    mem[2] = 24'hAAAAAA;
    mem[3] = 24'h555555;
    bus.update_request = 1'b0;
    bus.ram_q = '0;
    repeat (3) @(negedge CLK);
    chk("rst_dout", 32'(DOUT), 0);
    chk("rst_done", 32'(bus.update_done), 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_addr", 32'(bus.ram_rdaddress), 0);
    chk("rst_rden", 32'(bus.ram_rden), 0);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    run_frame(0);
    check_frame("A");
    bus.update_request = 1'b0;
    repeat (3) @(negedge CLK);
    run_frame(100);
    check_frame("B");
    bus.update_request = 1'b0;
    repeat (3) @(negedge CLK);
    bus.update_request = 1'b1;
    repeat (183) @(negedge CLK);
    chk("C_dout_bit30", 32'(DOUT), 1);
    #2 RST_N = 1'b0;
    #1;
    chk("C_rst_dout", 32'(DOUT), 0);
    chk("C_rst_done", 32'(bus.update_done), 1);
    chk("C_rst_busy", 32'(bus.busy), 0);
    chk("C_rst_addr", 32'(bus.ram_rdaddress), 0);
    bus.update_request = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    run_frame(0);
    check_frame("D");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
